// File: rtl/adder8_rr_scheduler_pkg.sv
// Shared types and constants for the adder8 round-robin scheduler.
//   state_t : scheduler FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   ADD_W   : operand / result width of the shared adder
package adder8_sched_pkg;
  localparam int ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;
endpackage

// File: rtl/adder8_rr_scheduler_if.sv
// Bus between the requester clients and the adder8 scheduler.
//   req_valid/req_a/req_b/req_ready : per-requester request handshake (lane i at index i)
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_overflow : single shared response channel
//   busy, txn_count : status
// master = client side, slave = scheduler side.
interface adder8_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  import adder8_sched_pkg::*;
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][ADD_W-1:0] req_a;
  logic [NREQ-1:0][ADD_W-1:0] req_b;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [ADD_W-1:0]           rsp_sum;
  logic                       rsp_overflow;
  logic                       busy;
  logic [CNT_W-1:0]           txn_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, busy, txn_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_overflow, busy, txn_count
  );
endinterface

// File: rtl/adder8.sv
// Combinational 8-bit two's complement adder with signed overflow flag.
//   a, b     : operands
//   sum      : (a + b) mod 256
//   overflow : operands share a sign and the result sign differs
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       overflow
);
  assign sum      = a + b;
  assign overflow = (a[7] == b[7]) && (sum[7] != a[7]);
endmodule

// File: rtl/adder8_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index granted most recently
//   grant_valid : any request present
//   grant_idx   : first set request searching upward from last_grant+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_idx
);
  // Walk from the farthest position back to the nearest so the closest
  // requester after last_grant is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NREQ]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'((int'(last_grant) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/adder8_rr_scheduler.sv
// Shares one adder8 among NREQ requesters.
//   clk, rst_n : clock, async active-low reset
//   bus        : request/response bus (slave side), see adder8_rr_scheduler_if
// One transaction every three cycles: accept in IDLE, add in EXEC, hold the
// registered result in RESP until the consumer takes it.
module adder8_rr_scheduler
  import adder8_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder8_rr_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ADD_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ADD_W-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [NREQ-1:0]  req_ready;

  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [ADD_W-1:0] add_sum;
  logic             add_ovf;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req         (bus.req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Adder sees only the captured operands, so the requester is free once accepted.
  adder8 u_add (
    .a        (op_a_q),
    .b        (op_b_q),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_ovf_d    = rsp_ovf_q;
    txn_d        = txn_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant_idx] = 1'b1;
          op_a_d       = bus.req_a[grant_idx];
          op_b_d       = bus.req_b[grant_idx];
          op_id_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_ovf_d   = add_ovf;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_ovf_q    <= 1'b0;
      txn_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
      txn_q        <= txn_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_sum      = rsp_sum_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.txn_count    = txn_q;
endmodule
